lc3_mem_responder: RTL and testbench
====================================

# lc3_mem_responder

Memory-side responder for the LC-3 datapath's MAR/MDR memory interface. It answers each request the control store issues (MEM.EN with R.W) by asserting the ready bit R after a fixed access latency, so microstates 33, 28, 25 and 16 can loop on R. It contains the word-addressed main RAM and the memory-mapped keyboard and display registers (KBSR/KBDR/DSR/DDR). It drives read data back toward MDR.

## Interface
- ADDR_WIDTH, 10: RAM holds 2^ADDR_WIDTH 16-bit words; MAR bits above this are ignored for RAM (aliasing).
- LATENCY, 2: cycles from request acceptance to R; legal range 1–15.
- INIT_FILE, "": optional $readmemh image for RAM; empty means no preload.

- i_CLK  in  1  sole clock; all state changes on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_MEM_EN  in  1  memory request from the control store.
- i_R_W  in  1  1 = write, 0 = read; sampled on acceptance.
- i_MAR  in  16  address; sampled on acceptance.
- i_MDR  in  16  write data; sampled on acceptance.
- o_R  out  1  ready bit; one-cycle pulse per access.
- o_Data  out  16  read data; valid while o_R is high, then held.
- i_KB_Valid  in  1  keyboard character strobe.
- i_KB_Data  in  8  keyboard character.
- o_KB_Overrun  out  1  sticky; a character arrived while KBSR[15] was set.
- o_Disp_Valid  out  1  one-cycle pulse on each DDR write.
- o_Disp_Data  out  8  DDR[7:0]; held until the next DDR write.
- i_Disp_Ack  in  1  display has consumed the character.

## Operation
- **FSM states:** IDLE, WAIT, READY, DONE.
  - IDLE: if i_MEM_EN, capture MAR/MDR/R_W, load counter with LATENCY-1, go to WAIT. If LATENCY=1, go directly to READY.
  - WAIT: decrement the counter; at 0, go to READY.
  - READY: o_R=1 for this cycle only; the access is performed on this cycle's closing edge; go to DONE.
  - DONE: return to IDLE once i_MEM_EN is low. A request is never re-accepted without an intervening low cycle.
- **Address decode (captured MAR):**
  - < xFE00: RAM[MAR[ADDR_WIDTH-1:0]].
  - xFE00 KBSR: read {KBSR[15], 15'b0}; writes ignored.
  - xFE02 KBDR: read {8'b0, KBDR}; the read clears KBSR[15]; writes ignored.
  - xFE04 DSR: read {DSR[15], 15'b0}; writes ignored.
  - xFE06 DDR: write latches o_Disp_Data=MDR[7:0], pulses o_Disp_Valid, clears DSR[15]; read returns 0.
  - Any other ≥ xFE00 address: reads 0, writes ignored.
- **Read data timing:** o_Data is driven combinationally from the decode during READY. It is registered at READY's edge and held until the next read's READY cycle. Writes leave o_Data unchanged.
- **Keyboard:**
  - i_KB_Valid with KBSR[15]=0 latches KBDR and sets KBSR[15].
  - i_KB_Valid with KBSR[15]=1 drops the character and sets o_KB_Overrun. o_KB_Overrun clears only on reset.
- **Display:** i_Disp_Ack sets DSR[15]. An ack in the same cycle as a DDR write is ignored, so DSR[15] stays 0.
- **Simultaneous KBDR read and i_KB_Valid:** the read returns the old KBDR. The new character is then latched and KBSR[15] ends at 1 (the set wins over the clear). No overrun is flagged.
- **Reset values:** state IDLE, o_R=0, o_Data=0, KBSR[15]=0, KBDR=0, DSR[15]=1, o_Disp_Valid=0, o_Disp_Data=0, o_KB_Overrun=0. RAM contents are not reset.
- **Reset mid-access:** the access is aborted, no RAM/DDR write commits, and no o_R pulse is issued.

## Timing
- i_MEM_EN is first high in cycle T and state is IDLE: o_R is high exactly in cycle T+LATENCY and low in every other cycle.
- A write is visible to a read accepted at T+LATENCY+2 or later.
- MAR/MDR changes after acceptance have no effect on the current access.
- Back-to-back throughput: one access per LATENCY+2 cycles (READY, DONE, IDLE).
- o_Disp_Valid is high in cycle T+LATENCY+1 of the DDR write.
- Keyboard and display inputs are sampled every cycle, independent of FSM state.

## Test plan
- **Reset:** assert i_Reset for 2 cycles → all outputs at their reset values; DSR read returns x8000; KBSR read returns x0000.
- **Write then read, LATENCY=2:**
  - Write x1234 to x3000 with MEM_EN high at cycle T → o_R high only at T+2.
  - Drop MEM_EN, then read x3000 → o_Data=x1234 with o_R.
  - Repeat with LATENCY=1 and LATENCY=5.
- **Keyboard path:**
  - KB_Valid with x41 → KBSR read returns x8000; KBDR read returns x0041; a following KBSR read returns x0000.
  - Two KB_Valid strobes without a KBDR read → o_KB_Overrun=1 and KBDR keeps the first character.
- **Display path:**
  - Write x0048 to xFE06 → one-cycle o_Disp_Valid with o_Disp_Data=x48; DSR reads x0000.
  - i_Disp_Ack → DSR reads x8000.
  - Ack in the same cycle as a DDR write → DSR stays x0000.
- **Held request and aliasing:**
  - Hold MEM_EN high for 10 cycles → exactly one o_R pulse.
  - Write to x0400 with ADDR_WIDTH=10 → read of x0000 returns the written value.
  - Read xFE08 → x0000.
- **Reset mid-write:** assert i_Reset during WAIT of a write x5555 to x0010 → no o_R pulse; RAM[x0010] unchanged; the next request completes normally.

Source files
------------

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: memory-side responder for the LC-3 MAR/MDR interface.
// Holds word-addressed main RAM plus the memory-mapped keyboard (KBSR/KBDR)
// and display (DSR/DDR) registers. Each request is answered with a one-cycle
// o_R pulse after a fixed latency.
//
// Handshake: i_MEM_EN is a level request. It is accepted only in IDLE, where
// i_R_W/i_MAR/i_MDR are captured. o_R is high for exactly one cycle (READY).
// The access commits on READY's closing edge. The FSM then waits in DONE
// until i_MEM_EN drops, so a held request is never accepted twice.
module lc3_mem_responder #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        i_CLK,
    input  logic        i_Reset,
    input  logic        i_MEM_EN,
    input  logic        i_R_W,
    input  logic [15:0] i_MAR,
    input  logic [15:0] i_MDR,
    output logic        o_R,
    output logic [15:0] o_Data,
    input  logic        i_KB_Valid,
    input  logic [7:0]  i_KB_Data,
    output logic        o_KB_Overrun,
    output logic        o_Disp_Valid,
    output logic [7:0]  o_Disp_Data,
    input  logic        i_Disp_Ack
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);
    localparam logic [15:0] KBSR_A = 16'hFE00;
    localparam logic [15:0] KBDR_A = 16'hFE02;
    localparam logic [15:0] DSR_A  = 16'hFE04;
    localparam logic [15:0] DDR_A  = 16'hFE06;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic [3:0]  cnt_nx;
    logic        capture;

    logic        rw_q;
    logic [15:0] mar_q;
    logic [15:0] mdr_q;

    logic [15:0] ram [0:(1 << ADDR_WIDTH) - 1];

    logic        kbsr;
    logic [7:0]  kbdr;
    logic        dsr;
    logic        overrun;
    logic [15:0] data_q;
    logic        disp_valid_q;
    logic [7:0]  disp_data_q;

    logic        ready;
    logic        is_io;
    logic [15:0] rd_data;
    logic        kbdr_rd;
    logic        ddr_wr;
    logic        ram_wr;
    logic        kb_take;

    // Next-state logic: accept, count down the latency, pulse READY, wait for release.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (i_MEM_EN) begin
                    capture = 1'b1;
                    cnt_nx  = LAT_M1;
                    if (LATENCY == 1) state_nx = READY;
                    else              state_nx = WAIT;
                end
            end
            WAIT: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) state_nx = READY;
            end
            READY:   state_nx = DONE;
            DONE:    if (!i_MEM_EN) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register and latency counter.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Capture the request so later MAR/MDR changes cannot affect it.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            rw_q  <= 1'b0;
            mar_q <= 16'h0000;
            mdr_q <= 16'h0000;
        end else if (capture) begin
            rw_q  <= i_R_W;
            mar_q <= i_MAR;
            mdr_q <= i_MDR;
        end
    end

    assign ready   = (state == READY);
    assign is_io   = (mar_q[15:9] == 7'b1111111);
    assign kbdr_rd = ready && !rw_q && (mar_q == KBDR_A);
    assign ddr_wr  = ready && rw_q && (mar_q == DDR_A);
    assign ram_wr  = ready && rw_q && !is_io && !i_Reset;
    // A KBDR read in the same cycle frees the buffer for the incoming character.
    assign kb_take = i_KB_Valid && (!kbsr || kbdr_rd);

    // Read decode from the captured address.
    always_comb begin
        rd_data = 16'h0000;
        if (!is_io) begin
            rd_data = ram[mar_q[ADDR_WIDTH-1:0]];
        end else begin
            case (mar_q)
                KBSR_A:  rd_data = {kbsr, 15'b0};
                KBDR_A:  rd_data = {8'h00, kbdr};
                DSR_A:   rd_data = {dsr, 15'b0};
                default: rd_data = 16'h0000;
            endcase
        end
    end

    // RAM write port; a reset in the READY cycle suppresses the commit.
    always_ff @(posedge i_CLK) begin
        if (ram_wr) ram[mar_q[ADDR_WIDTH-1:0]] <= mdr_q;
    end

    // Read data register: holds the last read until the next read's READY.
    always_ff @(posedge i_CLK) begin
        if (i_Reset)             data_q <= 16'h0000;
        else if (ready && !rw_q) data_q <= rd_data;
    end

    // Keyboard status/data; set beats a same-cycle clear from a KBDR read.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            kbsr    <= 1'b0;
            kbdr    <= 8'h00;
            overrun <= 1'b0;
        end else begin
            if (kb_take) begin
                kbdr <= i_KB_Data;
                kbsr <= 1'b1;
            end else if (kbdr_rd) begin
                kbsr <= 1'b0;
            end
            if (i_KB_Valid && kbsr && !kbdr_rd) overrun <= 1'b1;
        end
    end

    // Display: DDR write clears DSR and wins over a same-cycle ack.
    always_ff @(posedge i_CLK) begin
        if (i_Reset) begin
            dsr          <= 1'b1;
            disp_valid_q <= 1'b0;
            disp_data_q  <= 8'h00;
        end else begin
            disp_valid_q <= ddr_wr;
            if (ddr_wr) begin
                disp_data_q <= mdr_q[7:0];
                dsr         <= 1'b0;
            end else if (i_Disp_Ack) begin
                dsr <= 1'b1;
            end
        end
    end

    assign o_R          = ready;
    assign o_Data       = (ready && !rw_q) ? rd_data : data_q;
    assign o_KB_Overrun = overrun;
    assign o_Disp_Valid = disp_valid_q;
    assign o_Disp_Data  = disp_data_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench for lc3_mem_responder: three instances at LATENCY 2, 1 and 5
// share address/data inputs; only the LATENCY=2 instance sees keyboard/display.
module tb_lc3_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mem_en;
    logic        r_w;
    logic [15:0] mar;
    logic [15:0] mdr;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        disp_ack;

    wire  [2:0]  r_v;
    wire  [15:0] data_v [3];
    wire         overrun;
    wire         disp_valid;
    wire  [7:0]  disp_data;
    wire         l1_ovr, l1_dv, l5_ovr, l5_dv;
    wire  [7:0]  l1_dd, l5_dd;

    int checks = 0;
    int errors = 0;

    // Clock
    always #5 clk = ~clk;

    lc3_mem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) u_l2 (
        .i_CLK(clk), .i_Reset(rst), .i_MEM_EN(mem_en[0]), .i_R_W(r_w),
        .i_MAR(mar), .i_MDR(mdr), .o_R(r_v[0]), .o_Data(data_v[0]),
        .i_KB_Valid(kb_valid), .i_KB_Data(kb_data), .o_KB_Overrun(overrun),
        .o_Disp_Valid(disp_valid), .o_Disp_Data(disp_data), .i_Disp_Ack(disp_ack)
    );

    lc3_mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) u_l1 (
        .i_CLK(clk), .i_Reset(rst), .i_MEM_EN(mem_en[1]), .i_R_W(r_w),
        .i_MAR(mar), .i_MDR(mdr), .o_R(r_v[1]), .o_Data(data_v[1]),
        .i_KB_Valid(1'b0), .i_KB_Data(8'h00), .o_KB_Overrun(l1_ovr),
        .o_Disp_Valid(l1_dv), .o_Disp_Data(l1_dd), .i_Disp_Ack(1'b0)
    );

    lc3_mem_responder #(.ADDR_WIDTH(10), .LATENCY(5)) u_l5 (
        .i_CLK(clk), .i_Reset(rst), .i_MEM_EN(mem_en[2]), .i_R_W(r_w),
        .i_MAR(mar), .i_MDR(mdr), .o_R(r_v[2]), .o_Data(data_v[2]),
        .i_KB_Valid(1'b0), .i_KB_Data(8'h00), .o_KB_Overrun(l5_ovr),
        .o_Disp_Valid(l5_dv), .o_Disp_Data(l5_dd), .i_Disp_Ack(1'b0)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One access on instance idx. side[0] strobes the keyboard and side[1]
    // acks the display on READY's closing edge. Checks o_R timing and count.
    task automatic access(input int idx, input logic rw, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] side, input string tag,
                          output logic [15:0] rd, output int dv_cyc, output int dv_cnt);
        int lat;
        int first;
        int npulse;
        lat    = (idx == 0) ? 2 : ((idx == 1) ? 1 : 5);
        first  = -1;
        npulse = 0;
        dv_cyc = -1;
        dv_cnt = 0;
        rd     = 16'hDEAD;
        @(negedge clk);
        r_w         = rw;
        mar         = addr;
        mdr         = wd;
        mem_en[idx] = 1'b1;
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            if (r_v[idx]) begin
                npulse++;
                if (first < 0) first = k;
                rd = data_v[idx];
            end
            if (disp_valid) begin
                dv_cnt++;
                if (dv_cyc < 0) dv_cyc = k;
            end
            if (k == 1) begin
                mar = ~addr;
                mdr = ~wd;
                r_w = ~rw;
            end
            if (k == lat) begin
                kb_valid = side[0];
                disp_ack = side[1];
            end
            if (k == lat + 1) begin
                kb_valid    = 1'b0;
                disp_ack    = 1'b0;
                mem_en[idx] = 1'b0;
            end
        end
        check({tag, "_r_cycle"}, 16'(first), 16'(lat));
        check({tag, "_r_pulses"}, 16'(npulse), 16'd1);
    endtask

    task automatic kb_strobe(input logic [7:0] ch);
        @(negedge clk);
        kb_data  = ch;
        kb_valid = 1'b1;
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int dc;
        int dn;
        int np;

        // Reset
        rst = 1'b1; mem_en = 3'b000; r_w = 1'b0; mar = 16'h0; mdr = 16'h0;
        kb_valid = 1'b0; kb_data = 8'h00; disp_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_r", {13'b0, r_v}, 16'h0000);
        check("rst_data", data_v[0], 16'h0000);
        check("rst_overrun", {15'b0, overrun}, 16'h0000);
        check("rst_disp_valid", {15'b0, disp_valid}, 16'h0000);
        check("rst_disp_data", {8'h00, disp_data}, 16'h0000);
        access(0, 1'b0, 16'hFE04, 16'h0, 2'b00, "dsr_rst", rd, dc, dn);
        check("dsr_rst_val", rd, 16'h8000);
        access(0, 1'b0, 16'hFE00, 16'h0, 2'b00, "kbsr_rst", rd, dc, dn);
        check("kbsr_rst_val", rd, 16'h0000);

        // Write then read at each latency
        access(0, 1'b1, 16'h3000, 16'h1234, 2'b00, "wr_l2", rd, dc, dn);
        check("wr_keeps_data", data_v[0], 16'h0000);
        access(0, 1'b0, 16'h3000, 16'h0, 2'b00, "rd_l2", rd, dc, dn);
        check("rd_l2_val", rd, 16'h1234);
        check("rd_l2_hold", data_v[0], 16'h1234);
        access(1, 1'b1, 16'h3001, 16'hA5A5, 2'b00, "wr_l1", rd, dc, dn);
        access(1, 1'b0, 16'h3001, 16'h0, 2'b00, "rd_l1", rd, dc, dn);
        check("rd_l1_val", rd, 16'hA5A5);
        access(2, 1'b1, 16'h3002, 16'h0F0F, 2'b00, "wr_l5", rd, dc, dn);
        access(2, 1'b0, 16'h3002, 16'h0, 2'b00, "rd_l5", rd, dc, dn);
        check("rd_l5_val", rd, 16'h0F0F);

        // Keyboard
        kb_strobe(8'h41);
        access(0, 1'b0, 16'hFE00, 16'h0, 2'b00, "kbsr_full", rd, dc, dn);
        check("kbsr_full_val", rd, 16'h8000);
        access(0, 1'b0, 16'hFE02, 16'h0, 2'b00, "kbdr_41", rd, dc, dn);
        check("kbdr_41_val", rd, 16'h0041);
        access(0, 1'b0, 16'hFE00, 16'h0, 2'b00, "kbsr_clr", rd, dc, dn);
        check("kbsr_clr_val", rd, 16'h0000);

        // KBDR read coinciding with a new character
        kb_strobe(8'h44);
        kb_data = 8'h45;
        access(0, 1'b0, 16'hFE02, 16'h0, 2'b01, "kbdr_race", rd, dc, dn);
        check("kbdr_race_old", rd, 16'h0044);
        access(0, 1'b0, 16'hFE00, 16'h0, 2'b00, "kbsr_race", rd, dc, dn);
        check("kbsr_race_set", rd, 16'h8000);
        access(0, 1'b0, 16'hFE02, 16'h0, 2'b00, "kbdr_new", rd, dc, dn);
        check("kbdr_new_val", rd, 16'h0045);
        check("race_no_overrun", {15'b0, overrun}, 16'h0000);

        // Overrun
        kb_strobe(8'h42);
        kb_strobe(8'h43);
        check("overrun_set", {15'b0, overrun}, 16'h0001);
        access(0, 1'b0, 16'hFE02, 16'h0, 2'b00, "kbdr_keep", rd, dc, dn);
        check("kbdr_keep_val", rd, 16'h0042);

        // Display
        access(0, 1'b1, 16'hFE06, 16'h0048, 2'b00, "ddr_wr", rd, dc, dn);
        check("disp_valid_cycle", 16'(dc), 16'd3);
        check("disp_valid_count", 16'(dn), 16'd1);
        check("disp_data_val", {8'h00, disp_data}, 16'h0048);
        access(0, 1'b0, 16'hFE04, 16'h0, 2'b00, "dsr_busy", rd, dc, dn);
        check("dsr_busy_val", rd, 16'h0000);
        @(negedge clk);
        disp_ack = 1'b1;
        @(negedge clk);
        disp_ack = 1'b0;
        access(0, 1'b0, 16'hFE04, 16'h0, 2'b00, "dsr_ack", rd, dc, dn);
        check("dsr_ack_val", rd, 16'h8000);
        access(0, 1'b1, 16'hFE06, 16'h0049, 2'b10, "ddr_ack_race", rd, dc, dn);
        check("ddr_ack_race_data", {8'h00, disp_data}, 16'h0049);
        access(0, 1'b0, 16'hFE04, 16'h0, 2'b00, "dsr_race", rd, dc, dn);
        check("dsr_race_val", rd, 16'h0000);
        access(0, 1'b0, 16'hFE06, 16'h0, 2'b00, "ddr_rd", rd, dc, dn);
        check("ddr_rd_val", rd, 16'h0000);

        // Held request
        @(negedge clk);
        r_w = 1'b0; mar = 16'h3000; mem_en[0] = 1'b1;
        np = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (r_v[0]) np++;
        end
        mem_en[0] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (r_v[0]) np++;
        end
        check("held_pulses", 16'(np), 16'd1);
        check("held_data", data_v[0], 16'h1234);

        // Aliasing and unmapped I/O
        access(0, 1'b1, 16'h0400, 16'h7777, 2'b00, "alias_wr", rd, dc, dn);
        access(0, 1'b0, 16'h0000, 16'h0, 2'b00, "alias_rd", rd, dc, dn);
        check("alias_val", rd, 16'h7777);
        access(0, 1'b0, 16'hFE08, 16'h0, 2'b00, "unmapped", rd, dc, dn);
        check("unmapped_val", rd, 16'h0000);

        // Reset during WAIT of a write on the LATENCY=5 instance
        access(2, 1'b1, 16'h0010, 16'h1111, 2'b00, "pre_wr", rd, dc, dn);
        @(negedge clk);
        r_w = 1'b1; mar = 16'h0010; mdr = 16'h5555; mem_en[2] = 1'b1;
        np = 0;
        @(negedge clk);
        mem_en[2] = 1'b0;
        if (r_v[2]) np++;
        @(negedge clk);
        if (r_v[2]) np++;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (r_v[2]) np++;
        end
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (r_v[2]) np++;
        end
        check("abort_pulses", 16'(np), 16'd0);
        access(2, 1'b0, 16'h0010, 16'h0, 2'b00, "abort_rd", rd, dc, dn);
        check("abort_ram_val", rd, 16'h1111);
        access(0, 1'b0, 16'hFE04, 16'h0, 2'b00, "dsr_rst2", rd, dc, dn);
        check("dsr_rst2_val", rd, 16'h8000);

        // Report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
